hpdmc_rdcapture: RTL
====================

HPDMC_RDCAPTURE -- requirements
Module: hpdmc_rdcapture

Interface
REQ-001 Parameter DW, default 16: width of each DDR half-word delivered by the input DDR registers.
REQ-002 Parameter BURST, default 4: sys_clk beats per read burst, minimum 1.
REQ-003 Parameter MAX_LAT, default 8: depth of the read-latency delay line, minimum 2.
REQ-004 LW = ceil(log2(MAX_LAT)), minimum 1.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 read_issue  in  1  one-cycle pulse in the cycle a READ command is issued to the SDRAM.
REQ-008 lat  in  LW  cycles from read_issue to the first beat on q0/q1; legal 1..MAX_LAT-1; 0 treated as 1; held stable while busy.
REQ-009 swap  in  1  half-word order select.
REQ-010 q0  in  DW  rising-edge half-word from the DDR input registers.
REQ-011 q1  in  DW  falling-edge half-word from the DDR input registers.
REQ-012 dout  out  2*DW  assembled read word.
REQ-013 dout_valid  out  1  dout holds a burst beat.
REQ-014 dout_last  out  1  final beat of a complete burst; qualified by dout_valid.
REQ-015 busy  out  1  a read is pending in the delay line or being captured.
REQ-016 err_overlap  out  1  sticky flag: burst overlap detected.
REQ-017 err_clr  in  1  clears err_overlap.

Function
REQ-018 A MAX_LAT-bit shift register shall shift read_issue in every cycle; its tap at position lat (0 mapped to 1) shall be the start strobe.
REQ-019 Two states shall be used: IDLE and CAPTURE, with a beat counter 0..BURST-1.
REQ-020 Start in IDLE: enter CAPTURE, counter=0, and sample the current q0/q1 as beat 0.
REQ-021 In CAPTURE each cycle samples one beat and increments the counter; after sampling beat BURST-1 the block returns to IDLE unless a start occurs in the next cycle.
REQ-022 Beat k of a read issued in cycle N shall be sampled from q0/q1 during cycle N+lat+k and appear on dout with dout_valid=1 during cycle N+lat+k+1 (registered output; latency lat+1).
REQ-023 swap=0: dout={q0,q1}, q0 in the upper DW bits; swap=1: dout={q1,q0}.
REQ-024 dout_valid shall be 0 in every cycle not carrying a beat; dout shall hold its last value when dout_valid=0.
REQ-025 dout_last shall be 1 together with beat BURST-1 of a burst that was not truncated.
REQ-026 Reads spaced exactly BURST cycles apart shall produce contiguous dout_valid with no gap and no error.
REQ-027 A start arriving while CAPTURE is sampling beats 1..BURST-1 (spacing < BURST) shall set err_overlap, truncate the current burst without dout_last, and restart at beat 0 in the same cycle.
REQ-028 err_overlap is sticky until err_clr; if err_clr and a new overlap coincide, set wins.
REQ-029 busy=1 while any delay-line bit is set, while in CAPTURE, or while dout_valid=1.
REQ-030 BURST=1: every start yields one beat with dout_last=1; overlap is impossible.

Reset
REQ-031 sys_rst=1 at an edge clears the delay line, forces IDLE, zeroes the counter, and drives dout=0, dout_valid=0, dout_last=0, busy=0, err_overlap=0 from the next cycle.
REQ-032 Reset mid-burst aborts it; no further beats of pending or active reads are output after reset.

Verification
REQ-033 DW=16, BURST=4, lat=3, swap=0, read_issue in cycle 10, q0=0x1000+c, q1=0x2000+c (c = cycle) -> dout_valid in cycles 14..17, dout=0x100D200D..0x1010_2010, dout_last in cycle 17.
REQ-034 Same stimulus with swap=1 -> cycle 14 dout=0x200D100D.
REQ-035 read_issue in cycles 10 and 14, lat=2 -> dout_valid in cycles 13..20 with no gap, dout_last in cycles 16 and 20, err_overlap=0.
REQ-036 read_issue in cycles 10 and 12, lat=2 -> err_overlap=1 from cycle 15, dout_valid in cycles 13..18, dout_last only in cycle 18; err_clr in cycle 20 -> err_overlap=0 in cycle 21.
REQ-037 lat=0 -> behaves as lat=1: issue in cycle 10 -> first dout_valid in cycle 12.
REQ-038 sys_rst in cycle 15 during the burst of REQ-033 -> all outputs 0 from cycle 16, no later dout_valid.

Source files
------------

// File: rtl/hpdmc_rdcapture.sv
// Read-data capture for the DDR controller: delays each READ by a programmable
// latency, then assembles BURST beats of {q0,q1} into registered read words.
module hpdmc_rdcapture #(
    parameter int DW      = 16,
    parameter int BURST   = 4,
    parameter int MAX_LAT = 8,
    localparam int LW     = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT),
    localparam int CW     = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            read_issue,
    input  logic [LW-1:0]   lat,
    input  logic            swap,
    input  logic [DW-1:0]   q0,
    input  logic [DW-1:0]   q1,
    output logic [2*DW-1:0] dout,
    output logic            dout_valid,
    output logic            dout_last,
    output logic            busy,
    output logic            err_overlap,
    input  logic            err_clr
);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [MAX_LAT-1:0] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*DW-1:0]   dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              dl_q, dl_d;
    logic              err_q, err_d;

    logic [LW-1:0]     lat_eff;
    logic              start;
    logic              sample;
    logic [CW-1:0]     beat;

    // sr_q[k] holds read_issue from k+1 cycles ago, so tap lat-1 fires lat cycles after issue.
    always_comb begin
        lat_eff = lat;
        if (lat == '0)
            lat_eff = LW'(1);
        else if (lat > LW'(MAX_LAT - 1))
            lat_eff = LW'(MAX_LAT - 1);
        start = sr_q[lat_eff - LW'(1)];
        sr_d  = {sr_q[MAX_LAT-2:0], read_issue};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        dl_d    = 1'b0;
        err_d   = err_q & ~err_clr;
        sample  = 1'b0;
        beat    = cnt_q;

        // CAPTURE only ever covers beats 1..BURST-1, so a start seen there is an overlap.
        if (start) begin
            sample = 1'b1;
            beat   = '0;
            if (state_q == CAPTURE)
                err_d = 1'b1;
        end else if (state_q == CAPTURE) begin
            sample = 1'b1;
        end

        if (sample) begin
            dout_d = swap ? {q1, q0} : {q0, q1};
            dv_d   = 1'b1;
            if (beat == CW'(BURST - 1)) begin
                dl_d    = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = CAPTURE;
                cnt_d   = beat + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            dl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            dl_q    <= dl_d;
            err_q   <= err_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dv_q;
    assign dout_last   = dl_q;
    assign err_overlap = err_q;
    assign busy        = (|sr_q) | (state_q == CAPTURE) | dv_q;

endmodule
